// File: rtl/sigma_alu_arbiter.sv
// sigma_alu_arbiter: round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Ports: clk, rst_n (async, active-low); requester side req_valid/req_ready/req_op/req_a/req_b
// (+ req_lock with SIGMA_ALU_ARB_LOCK_EN); shared ALU port alu_op/alu_a/alu_b/alu_result;
// response register rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_err.
// Opcode map: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7, 8..15 illegal.
// Define SIGMA_ALU_ARB_LOCK_EN to add req_lock and the sticky lock on the granted requester.
module sigma_alu_arbiter #(
  parameter int NREQ = 4,
  parameter int XLEN = 32,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
`ifdef SIGMA_ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [3:0]           alu_op,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err
);
  localparam logic [3:0] ALU_ADD = 4'b0000;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic            can_issue, found, hs, ill, hold_rr, fwd;
  logic [IDW-1:0]  gid;
  logic [3:0]      gop;
  logic [IDW:0]    s;
`ifdef SIGMA_ALU_ARB_LOCK_EN
  logic            lock_valid_q, lock_valid_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;
`endif
  // Circular scan from rr_q; one extra bit on s keeps the wrap correct for non-power-of-2 NREQ.
  always_comb begin
    found = 1'b0;
    gid = '0;
    s = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, rr_q} + (IDW+1)'(k);
      if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
      if (!found && req_valid[s[IDW-1:0]]) begin
        found = 1'b1;
        gid = s[IDW-1:0];
      end
    end
`ifdef SIGMA_ALU_ARB_LOCK_EN
    if (lock_valid_q && req_valid[lock_id_q]) begin
      found = 1'b1;
      gid = lock_id_q;
    end
`endif
  end
  assign can_issue = rst_n && (!rsp_valid_q || rsp_ready);
  assign hs        = found && can_issue;
  assign gop       = req_op[4*gid +: 4];
  assign ill       = gop[3];
  assign fwd       = hs && !ill;
  assign req_ready = hs ? (NREQ'(1) << gid) : '0;
  assign alu_op    = fwd ? gop : ALU_ADD;
  assign alu_a     = fwd ? req_a[XLEN*gid +: XLEN] : '0;
  assign alu_b     = fwd ? req_b[XLEN*gid +: XLEN] : '0;
`ifdef SIGMA_ALU_ARB_LOCK_EN
  assign hold_rr      = req_lock[gid];
  assign lock_valid_d = hs ? req_lock[gid] : (can_issue && !req_valid[lock_id_q]) ? 1'b0 : lock_valid_q;
  assign lock_id_d    = hs ? gid : lock_id_q;
`else
  assign hold_rr = 1'b0;
`endif
  always_comb begin
    rsp_valid_d = hs || (rsp_valid_q && !rsp_ready);
    rsp_data_d  = hs ? (ill ? '0 : alu_result) : rsp_data_q;
    rsp_id_d    = hs ? gid : rsp_id_q;
    rsp_err_d   = hs ? ill : rsp_err_q;
    rr_d        = (hs && !hold_rr) ? ((gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1) : rr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      rr_q         <= '0;
`ifdef SIGMA_ALU_ARB_LOCK_EN
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
`endif
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rr_q         <= rr_d;
`ifdef SIGMA_ALU_ARB_LOCK_EN
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
`endif
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: doc/sigma_alu_arbiter.md
# sigma_alu_arbiter

Round-robin arbiter that shares one combinational SigmaCore ALU between `NREQ` requesters, such as the integer pipeline, the address-generation unit and the debug unit. It has the following jobs:
- Select one valid request per cycle.
- Drive the selected opcode and operands onto the shared ALU port.
- Register the ALU result, tagged with the winning requester's id, into a single-entry response register with valid/ready back-pressure.

Opcodes are the 4-bit `ALU_*` encodings from `sigma_pkg`.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `XLEN`, default 32: operand and result width.
- `IDW`, default `$clog2(NREQ)`: width of the requester id; derived, not overridden.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `NREQ`: request valid, one bit per requester.
- `req_ready` out `NREQ`: grant/accept, one-hot or zero.
- `req_op` in `NREQ*4`: opcode of requester i at bits `[4i+3:4i]`.
- `req_a` in `NREQ*XLEN`: operand A of requester i at slice i.
- `req_b` in `NREQ*XLEN`: operand B of requester i at slice i.
- `req_lock` in `NREQ`: lock hint; present only with `SIGMA_ALU_ARB_LOCK_EN`.
- `alu_op` out 4: opcode driven to the shared ALU.
- `alu_a` out `XLEN`: operand A driven to the shared ALU.
- `alu_b` out `XLEN`: operand B driven to the shared ALU.
- `alu_result` in `XLEN`: combinational ALU result, same cycle.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out `XLEN`: registered result.
- `rsp_id` out `IDW`: index of the requester that produced `rsp_data`.
- `rsp_err` out 1: the opcode was illegal (4'b1000–4'b1111).

## Operation
- **Issue condition:** `can_issue = !rsp_valid || rsp_ready`. This is combinational from `rsp_ready`.
- **Grant selection:** when `can_issue` is high, grant the first valid requester, scanning circularly from `rr_ptr`.
  - `req_ready` is high only for the granted requester.
  - `req_ready` may depend on `req_valid` and `rsp_ready`.
  - Requesters must hold `op`, `a` and `b` stable while `req_valid` is high.
- **ALU port:**
  - With a grant: `alu_op`, `alu_a` and `alu_b` carry the granted requester's fields.
  - Without a grant: they carry `ALU_ADD` with zero operands.
- **Handshake:** a request transfers on `req_valid[i] && req_ready[i]`. On that edge:
  - `rsp_data <= alu_result`
  - `rsp_id <= i`
  - `rsp_err <= (op[3] == 1)`
  - `rsp_valid <= 1`
  - `rr_ptr <= (i+1) mod NREQ`, wrapping from `NREQ-1` to 0.
- **Illegal opcode:** the request is still accepted. `rsp_data = 0`, `rsp_err = 1`, and the ALU port is driven with `ALU_ADD` and zeros.
- **Response drain:**
  - If the response is accepted and no new request arrives in the same cycle, `rsp_valid` drops to 0.
  - If the response is accepted and a new request arrives in the same cycle, the register reloads with the new result and `rsp_valid` stays 1.
- **Stall:** while `rsp_valid && !rsp_ready`, all `req_ready` bits are 0. `rsp_data`, `rsp_id`, `rsp_err` and `rr_ptr` hold.
- **Lock state:** `lock_valid`/`lock_id` (used only with `SIGMA_ALU_ARB_LOCK_EN`).
- **Reset:**
  - `rsp_valid`, `rsp_data`, `rsp_id`, `rsp_err` = 0.
  - `rr_ptr` = 0, so requester 0 has top priority first.
  - Lock state cleared.
  - Reset asserted mid-operation discards any pending response, and no grant is issued while `rst_n` is low.

## Timing
- Latency: a request accepted at edge N gives `rsp_valid` = 1 after edge N, visible in cycle N+1.
- Throughput: one operation per cycle when `rsp_ready` is held high.
- Fairness: with all `NREQ` requesters continuously valid, each is granted exactly once every `NREQ` accepted operations.
- Combinational paths:
  - `rsp_ready` → `req_ready`
  - `req_*` → `alu_*`
  - `alu_result` → `rsp_data` D-input
- No path exists from `rsp_ready` to `rsp_data`/`rsp_valid` outputs without passing through a register.

## Configuration
- `SIGMA_ALU_ARB_LOCK_EN` defined:
  - The `req_lock` port exists.
  - If the granted requester has `req_lock[i] = 1` at the handshake, set `lock_valid = 1` and `lock_id = i`, and do not advance `rr_ptr`.
  - While `lock_valid` is set and `req_valid[lock_id]` is high, `lock_id` wins the next arbitration regardless of `rr_ptr`.
  - The lock clears on the first handshake by `lock_id` with `req_lock = 0`, or when `req_valid[lock_id]` is low at an issue opportunity. The normal round-robin advance then resumes.
- `SIGMA_ALU_ARB_LOCK_EN` undefined: the `req_lock` port is absent, there is no lock state, and arbitration is pure round-robin.

## Test plan
- **Reset state:** after reset, `rsp_valid`/`rsp_data`/`rsp_id`/`rsp_err` = 0. Then requesters 0 and 3 both valid: requester 0 is granted first, requester 3 next.
- **Single op:** req1 sends `ALU_SUB` with A=10, B=3, `rsp_ready` = 1 → next cycle `rsp_valid` = 1, `rsp_data` = 7, `rsp_id` = 1, `rsp_err` = 0.
- **Fair sharing:** all 4 requesters valid for 8 cycles with `rsp_ready` = 1 → `rsp_id` sequence is 0, 1, 2, 3, 0, 1, 2, 3, with no gaps.
- **Back-pressure:** `rsp_ready` = 0 for 3 cycles with a response pending → `req_ready` = 0 and the response holds. When `rsp_ready` rises, the next request is accepted in that same cycle, and `rsp_valid` stays 1.
- **Illegal opcode:** req2 sends op 4'b1010 → accepted, then `rsp_data` = 0, `rsp_err` = 1, `rsp_id` = 2.
- **Lock (macro on) and mid-op reset:**
  - req0 issues 3 ops with `req_lock` = 1, 1, 0 while req1 is valid → responses come out as 0, 0, 0, 1.
  - Assert `rst_n` low while a response is pending → `rsp_valid` = 0 immediately.
